prog_counter: RTL

Parametrised programmable up/down counter: next generation of the basic load/enable counter. Adds a runtime step size, a programmable upper limit, three overflow modes (wrap-modulo, saturate, one-shot halt) and a synchronous clear. It is a standalone leaf datapath block for timers, address generators and event counters, driven by the existing counter interface style plus the new control fields.

---
 rtl/prog_counter_pkg.sv | 32 +++
 rtl/prog_counter_step.sv | 77 +++++++
 rtl/prog_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types and helpers for the programmable up/down counter.
// Counter width must not exceed CLAMP_W because load clamping is done at that width.
package prog_counter_pkg;

    localparam int CLAMP_W = 64;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // The unused encoding 2'b11 behaves as wrap.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_SAT;
            2'b10:   return MODE_ONESHOT;
            default: return MODE_WRAP;
        endcase
    endfunction

    function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] data,
                                                      input logic [CLAMP_W-1:0] limit);
        return (data > limit) ? limit : data;
    endfunction

endpackage

// File: rtl/prog_counter_step.sv
// Combinational next-count datapath: one up/down step against the limit,
// producing the new count, the overflow/underflow flags and a one-shot halt request.
module prog_counter_step
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic [WIDTH-1:0]      i_count,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0]      i_limit,
    input  logic                  i_up,
    input  mode_e                 i_mode,
    output logic [WIDTH-1:0]      o_next,
    output logic                  o_ovf,
    output logic                  o_udf,
    output logic                  o_halt_req
);

    // Two guard bits: one for the carry of count+step, one so a negative
    // down-wrap result shows up as a huge unsigned value.
    localparam int EW = WIDTH + 2;

    logic [EW-1:0] count_x;
    logic [EW-1:0] step_x;
    logic [EW-1:0] limit_x;
    logic [EW-1:0] limit_p1;
    logic [EW-1:0] sum;
    logic [EW-1:0] wrap_up;
    logic [EW-1:0] wrap_dn;

    assign count_x  = EW'(i_count);
    assign step_x   = EW'(i_step);
    assign limit_x  = EW'(i_limit);
    assign limit_p1 = limit_x + EW'(1);
    assign sum      = count_x + step_x;
    assign wrap_up  = sum - limit_p1;
    assign wrap_dn  = limit_p1 + count_x - step_x;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_next     = i_count;
        o_ovf      = 1'b0;
        o_udf      = 1'b0;
        o_halt_req = 1'b0;

        if (i_step != '0) begin
            if (i_up) begin
                if (sum > limit_x) begin
                    o_ovf = 1'b1;
                    if (i_mode == MODE_WRAP) begin
                        // A step larger than the whole range cannot be wrapped meaningfully.
                        o_next = (step_x > limit_p1) ? '0 : WIDTH'(wrap_up);
                    end else begin
                        o_next     = i_limit;
                        o_halt_req = (i_mode == MODE_ONESHOT);
                    end
                end else begin
                    o_next = WIDTH'(sum);
                end
            end else begin
                if (count_x < step_x) begin
                    o_udf = 1'b1;
                    if (i_mode == MODE_WRAP) begin
                        o_next = (wrap_dn > limit_x) ? '0 : WIDTH'(wrap_dn);
                    end else begin
                        o_next     = '0;
                        o_halt_req = (i_mode == MODE_ONESHOT);
                    end
                end else begin
                    o_next = WIDTH'(count_x - step_x);
                end
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter: clear > load > enable priority, wrap/saturate/one-shot
// overflow handling, registered count and single-cycle ovf/udf pulses.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_up_down,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_data,
    input  logic                  i_clear,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0]      i_limit,
    input  logic [1:0]            i_mode,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_ovf,
    output logic                  o_udf,
    output logic                  o_halted
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    state_e           state_q, state_d;

    mode_e            mode;
    logic [WIDTH-1:0] step_next;
    logic             step_ovf;
    logic             step_udf;
    logic             step_halt_req;
    logic [WIDTH-1:0] load_value;

    assign mode       = decode_mode(i_mode);
    assign load_value = WIDTH'(clamp_load(CLAMP_W'(i_load_data), CLAMP_W'(i_limit)));

    prog_counter_step #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step (
        .i_count    (count_q),
        .i_step     (i_step),
        .i_limit    (i_limit),
        .i_up       (i_up_down),
        .i_mode     (mode),
        .o_next     (step_next),
        .o_ovf      (step_ovf),
        .o_udf      (step_udf),
        .o_halt_req (step_halt_req)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        state_d = state_q;

        if (i_clear) begin
            count_d = '0;
            state_d = ST_RUN;
        end else if (i_load) begin
            count_d = load_value;
            state_d = ST_RUN;
        end else if (i_en && (state_q == ST_RUN)) begin
            count_d = step_next;
            ovf_d   = step_ovf;
            udf_d   = step_udf;
            if (step_halt_req) begin
                state_d = ST_HALT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            state_q <= state_d;
        end
    end

    assign o_count  = count_q;
    assign o_ovf    = ovf_q;
    assign o_udf    = udf_q;
    assign o_halted = (state_q == ST_HALT);

endmodule
